// File: rtl/elm_output_sequencer.sv
// ---------------------------------------------------------------------------
// elm_output_sequencer
// Drives the ELM output layer once the hidden-activation RAM is full. For
// each class it streams NUM_HIDDEN hidden/beta reads into the shared MAC,
// then compares the class score against a running maximum. The winning class
// index is returned over a valid/ready handshake.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin classification (sampled only when idle)
//   rd_en           read strobe to hidden RAM / beta ROM (1-cycle latency)
//   hid_addr        hidden RAM address
//   beta_addr       beta ROM address (cls*NUM_HIDDEN + hid)
//   en_acc          accumulator enable, rd_en delayed by one cycle
//   rst_acc         synchronous accumulator clear, one pulse per class
//   acc_in          registered signed accumulator value
//   busy            high whenever the sequencer is not idle
//   result_class    winning class index
//   result_valid    result available
//   result_ready    consumer accepts the result
//   max_score       winning score (only when SCORE_OUT_EN is defined)
//
// Build option: define SCORE_OUT_EN to expose the max_score output.
// ---------------------------------------------------------------------------
module elm_output_sequencer #(
    parameter int unsigned NUM_HIDDEN = 10,
    parameter int unsigned NUM_CLASS  = 10,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned HID_AW     = 4,
    parameter int unsigned BETA_AW    = 7,
    parameter int unsigned CLS_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      rd_en,
    output logic [HID_AW-1:0]         hid_addr,
    output logic [BETA_AW-1:0]        beta_addr,
    output logic                      en_acc,
    output logic                      rst_acc,
    input  logic signed [ACC_W-1:0]   acc_in,
    output logic                      busy,
    output logic [CLS_W-1:0]          result_class,
    output logic                      result_valid,
    input  logic                      result_ready
`ifdef SCORE_OUT_EN
    ,
    output logic signed [ACC_W-1:0]   max_score
`endif
);

    localparam logic [HID_AW-1:0] HID_LAST = HID_AW'(NUM_HIDDEN - 1);
    localparam logic [CLS_W-1:0]  CLS_LAST = CLS_W'(NUM_CLASS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [HID_AW-1:0]        hid_cnt_q, hid_cnt_d;
    logic [CLS_W-1:0]         cls_cnt_q, cls_cnt_d;
    logic [BETA_AW-1:0]       beta_addr_q, beta_addr_d;
    logic signed [ACC_W-1:0]  max_q, max_d;
    logic [CLS_W-1:0]         idx_q, idx_d;
    logic                     rd_en_q, rd_en_d;
    logic                     en_acc_q;
    logic                     rst_acc_q, rst_acc_d;
    logic                     busy_q, busy_d;
    logic                     result_valid_q, result_valid_d;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR:   state_d = S_MAC;
            S_MAC:   if (hid_cnt_q == HID_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_CMP;
            S_CMP:   state_d = (cls_cnt_q == CLS_LAST) ? S_DONE : S_CLR;
            S_DONE:  if (result_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values. Strobes are decoded from the next
    // state so the registered outputs line up with the state they belong to.
    always_comb begin
        hid_cnt_d      = hid_cnt_q;
        cls_cnt_d      = cls_cnt_q;
        beta_addr_d    = beta_addr_q;
        max_d          = max_q;
        idx_d          = idx_q;
        rd_en_d        = (state_d == S_MAC);
        rst_acc_d      = (state_d == S_CLR);
        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cls_cnt_d   = '0;
                    beta_addr_d = '0;
                end
            end
            S_CLR: begin
                hid_cnt_d = '0;
            end
            S_MAC: begin
                // Hold on the last tap so the addresses never run past the end.
                if (hid_cnt_q != HID_LAST) begin
                    hid_cnt_d   = hid_cnt_q + HID_AW'(1);
                    beta_addr_d = beta_addr_q + BETA_AW'(1);
                end
            end
            S_CMP: begin
                // Strictly greater: ties keep the lower class index.
                if ((cls_cnt_q == '0) || (acc_in > max_q)) begin
                    max_d = acc_in;
                    idx_d = cls_cnt_q;
                end
                // Step the beta address onto the first tap of the next class.
                if (cls_cnt_q != CLS_LAST) begin
                    cls_cnt_d   = cls_cnt_q + CLS_W'(1);
                    beta_addr_d = beta_addr_q + BETA_AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hid_cnt_q      <= '0;
            cls_cnt_q      <= '0;
            beta_addr_q    <= '0;
            max_q          <= '0;
            idx_q          <= '0;
            rd_en_q        <= 1'b0;
            en_acc_q       <= 1'b0;
            rst_acc_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            hid_cnt_q      <= hid_cnt_d;
            cls_cnt_q      <= cls_cnt_d;
            beta_addr_q    <= beta_addr_d;
            max_q          <= max_d;
            idx_q          <= idx_d;
            rd_en_q        <= rd_en_d;
            en_acc_q       <= rd_en_q;
            rst_acc_q      <= rst_acc_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign rd_en        = rd_en_q;
    assign hid_addr     = hid_cnt_q;
    assign beta_addr    = beta_addr_q;
    assign en_acc       = en_acc_q;
    assign rst_acc      = rst_acc_q;
    assign busy         = busy_q;
    assign result_class = idx_q;
    assign result_valid = result_valid_q;
`ifdef SCORE_OUT_EN
    assign max_score    = max_q;
`endif

endmodule

// File: tb/tb_elm_output_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for elm_output_sequencer: hidden RAM, beta ROM and MAC accumulator
// are modelled around the DUT; expected winners come from a dot-product /
// argmax reference model and are checked by a handshake monitor.
// ---------------------------------------------------------------------------
module tb_elm_output_sequencer;

    localparam int NH      = 10;
    localparam int NC      = 10;
    localparam int ACC_W   = 32;
    localparam int HID_AW  = 4;
    localparam int BETA_AW = 7;
    localparam int CLS_W   = 4;
    localparam int LAT     = NC * (NH + 3);

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     rd_en;
    logic [HID_AW-1:0]        hid_addr;
    logic [BETA_AW-1:0]       beta_addr;
    logic                     en_acc;
    logic                     rst_acc;
    logic signed [ACC_W-1:0]  acc_in;
    logic                     busy;
    logic [CLS_W-1:0]         result_class;
    logic                     result_valid;
    logic                     result_ready;
`ifdef SCORE_OUT_EN
    logic signed [ACC_W-1:0]  max_score;
`endif

    elm_output_sequencer #(
        .NUM_HIDDEN (NH),
        .NUM_CLASS  (NC),
        .ACC_W      (ACC_W),
        .HID_AW     (HID_AW),
        .BETA_AW    (BETA_AW),
        .CLS_W      (CLS_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rd_en        (rd_en),
        .hid_addr     (hid_addr),
        .beta_addr    (beta_addr),
        .en_acc       (en_acc),
        .rst_acc      (rst_acc),
        .acc_in       (acc_in),
        .busy         (busy),
        .result_class (result_class),
        .result_valid (result_valid),
        .result_ready (result_ready)
`ifdef SCORE_OUT_EN
        ,
        .max_score    (max_score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memories and accumulator environment ----------------
    int hid_mem  [NH];
    int beta_mem [NH*NC];
    int hid_rd   = 0;
    int beta_rd  = 0;
    int acc      = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            hid_rd  <= (int'(hid_addr)  < NH)    ? hid_mem[hid_addr]   : 0;
            beta_rd <= (int'(beta_addr) < NH*NC) ? beta_mem[beta_addr] : 0;
        end
        if (rst_acc)     acc <= 0;
        else if (en_acc) acc <= acc + hid_rd * beta_rd;
    end
    assign acc_in = acc;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int cls;
        int score;
    } exp_t;

    exp_t exp_q[$];

    // Winner = lowest class index among those holding the largest dot product.
    function automatic exp_t model();
        int   sc[NC];
        int   mx;
        exp_t e;
        for (int c = 0; c < NC; c++) begin
            sc[c] = 0;
            for (int h = 0; h < NH; h++) sc[c] += hid_mem[h] * beta_mem[c*NH + h];
        end
        mx = sc[0];
        for (int c = 1; c < NC; c++) if (sc[c] > mx) mx = sc[c];
        e.cls = -1;
        for (int c = NC - 1; c >= 0; c--) if (sc[c] == mx) e.cls = c;
        e.score = mx;
        return e;
    endfunction

    // ---------------- monitor: all comparisons live here ----------------
    int  checks = 0;
    int  errors = 0;
    bit  tb_done = 1'b0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    bit          active     = 1'b0;
    bit          valid_seen = 1'b0;
    bit          post_hs    = 1'b0;
    bit          prev_rd    = 1'b0;
    bit          prev_rst   = 1'b1;
    int          lat        = 0;
    int          rd_cnt     = 0;
    int          rst_cnt    = 0;
    logic [CLS_W-1:0] held_cls = '0;
    exp_t        got;

    always @(negedge clk) begin
        if (tb_done) begin
            chk("pending_expectations", exp_q.size(), 0);
            chk("final_busy", busy, 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else if (rst) begin
            chk("rst_rd_en", rd_en, 0);
            chk("rst_en_acc", en_acc, 0);
            chk("rst_rst_acc", rst_acc, 0);
            chk("rst_busy", busy, 0);
            chk("rst_result_valid", result_valid, 0);
            chk("rst_result_class", result_class, 0);
            chk("rst_hid_addr", hid_addr, 0);
            chk("rst_beta_addr", beta_addr, 0);
`ifdef SCORE_OUT_EN
            chk("rst_max_score", max_score, 0);
`endif
            active     = 1'b0;
            valid_seen = 1'b0;
            post_hs    = 1'b0;
            exp_q.delete();
        end else begin
            if (!prev_rst) chk("en_acc_lags_rd_en", en_acc, prev_rd);
            if (post_hs) begin
                chk("valid_drops_after_handshake", result_valid, 0);
                chk("idle_after_handshake", busy, 0);
                post_hs = 1'b0;
            end else if (!active) begin
                chk("no_spurious_valid", result_valid, 0);
            end

            if (active) begin
                // lat counts clock edges since the start was seen, the
                // start-sampling edge included.
                lat++;
                if (rd_en) begin
                    chk("hid_addr", hid_addr, rd_cnt % NH);
                    chk("beta_addr", beta_addr, rd_cnt);
                    rd_cnt++;
                end
                if (rst_acc) rst_cnt++;
                if (result_valid) begin
                    if (!valid_seen) begin
                        chk("result_latency", lat, LAT + 1);
                        chk("rd_en_cycles", rd_cnt, NC * NH);
                        chk("rst_acc_pulses", rst_cnt, NC);
                        held_cls   = result_class;
                        valid_seen = 1'b1;
                    end else begin
                        chk("result_class_stable", result_class, held_cls);
                    end
                    chk("busy_in_done", busy, 1);
                    if (result_ready) begin
                        chk("result_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            got = exp_q.pop_front();
                            chk("result_class", result_class, got.cls);
`ifdef SCORE_OUT_EN
                            chk("max_score", max_score, got.score);
`endif
                        end
                        post_hs    = 1'b1;
                        active     = 1'b0;
                        valid_seen = 1'b0;
                    end
                end else if (lat > LAT + 200) begin
                    chk("result_latency", lat, LAT + 1);
                    active = 1'b0;
                end
            end else if (start && !busy) begin
                active  = 1'b1;
                lat     = 0;
                rd_cnt  = 0;
                rst_cnt = 0;
            end
        end
        prev_rd  = rd_en;
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    task automatic load_directed(input int sc[NC]);
        for (int h = 0; h < NH; h++) hid_mem[h] = 1;
        for (int i = 0; i < NH*NC; i++) beta_mem[i] = 0;
        for (int c = 0; c < NC; c++) beta_mem[c*NH + (c % NH)] = sc[c];
    endtask

    task automatic load_random();
        for (int h = 0; h < NH; h++) hid_mem[h] = int'($urandom_range(0, 15));
        for (int i = 0; i < NH*NC; i++) beta_mem[i] = int'($urandom_range(0, 200)) - 100;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input int hold, input bit mid_start, input bit ready_start);
        int n;
        exp_q.push_back(model());
        pulse_start();
        if (mid_start) begin
            repeat (40) @(posedge clk);
            #1;
            pulse_start();
        end
        n = 0;
        while (!result_valid && n < LAT + 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (hold) @(posedge clk);
        #1;
        result_ready = 1'b1;
        start        = ready_start;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    int sc_a[NC];

    initial begin
        int n;
        rst          = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Mixed scores: class 2 wins.
        sc_a = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
        load_directed(sc_a);
        run(0, 1'b0, 1'b0);

        // All tied: lowest index wins; consumer stalls for 20 cycles.
        sc_a = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
        load_directed(sc_a);
        run(20, 1'b0, 1'b0);

        // All negative, maximum -1 at the last class.
        sc_a = '{-20, -19, -18, -17, -16, -15, -14, -13, -12, -1};
        load_directed(sc_a);
        run(2, 1'b0, 1'b0);

        // Reset in the middle of class 4 aborts the run.
        load_random();
        exp_q.push_back(model());
        pulse_start();
        n = 0;
        while (!(rd_en && int'(beta_addr) == 4*NH) && n < LAT + 300) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Randomized runs, including an ignored mid-run start and a start
        // coinciding with the accepting handshake.
        for (int r = 0; r < 7; r++) begin
            load_random();
            run(int'($urandom_range(0, 4)), r == 2, r == 4);
        end

        repeat (20) @(posedge clk);
        #1 tb_done = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
